// File: rtl/addr_window_map_pkg.sv
// Shared types for addr_window_map: config field codes, flag bit
// indices and the window-entry struct used by shadow/active tables.
package map_win_pkg;

  localparam int MAP_ADDR_W = 24;

  typedef enum logic [1:0] {
    FIELD_BASE   = 2'd0,
    FIELD_MASK   = 2'd1,
    FIELD_TARGET = 2'd2,
    FIELD_FLAGS  = 2'd3
  } cfg_field_e;

  localparam int FLAG_EN = 0;
  localparam int FLAG_WR = 1;

  typedef struct packed {
    logic [MAP_ADDR_W-1:0] base;
    logic [MAP_ADDR_W-1:0] mask;
    logic [MAP_ADDR_W-1:0] target;
    logic [1:0]            flags;
  } map_entry_t;

  function automatic logic [1:0] flags_of(
    input logic [MAP_ADDR_W-1:0] d
  );
    return d[1:0];
  endfunction

endpackage

// File: rtl/addr_window_map_if.sv
// Config + lookup bundle of addr_window_map.
// master: MCU/bus-sampler side; slave: the mapper.
interface addr_window_map_if #(
  parameter int ADDR_W    = 24,
  parameter int WIN_IDX_W = 4
);
  logic                 cfg_we;
  logic [WIN_IDX_W-1:0] cfg_win;
  logic [1:0]           cfg_field;
  logic [ADDR_W-1:0]    cfg_wdata;
  logic                 cfg_commit;
  logic [15:0]          cfg_rdata;

  logic                 req_valid;
  logic [ADDR_W-1:0]    req_addr;
  logic                 req_write;

  logic                 resp_valid;
  logic                 resp_hit;
  logic [WIN_IDX_W-1:0] resp_win;
  logic [ADDR_W-1:0]    resp_addr;
  logic                 resp_wr_fault;

  modport master (
    output cfg_we, cfg_win, cfg_field,
    output cfg_wdata, cfg_commit,
    input  cfg_rdata,
    output req_valid, req_addr, req_write,
    input  resp_valid, resp_hit, resp_win,
    input  resp_addr, resp_wr_fault
  );

  modport slave (
    input  cfg_we, cfg_win, cfg_field,
    input  cfg_wdata, cfg_commit,
    output cfg_rdata,
    input  req_valid, req_addr, req_write,
    output resp_valid, resp_hit, resp_win,
    output resp_addr, resp_wr_fault
  );
endinterface

// File: rtl/addr_window_map_match.sv
// map_win_match: combinational match + translate for one window.
// in: entry, addr; out: match, xlat.
module map_win_match
  import map_win_pkg::*;
(
  input  map_entry_t            entry,
  input  logic [MAP_ADDR_W-1:0] addr,
  output logic                  match,
  output logic [MAP_ADDR_W-1:0] xlat
);

  assign match = entry.flags[FLAG_EN] &&
    ((addr & entry.mask) == (entry.base & entry.mask));

  // carry out of the add is dropped: wraps mod 2**ADDR_W
  assign xlat = entry.target + (addr & ~entry.mask);

endmodule

// File: rtl/addr_window_map.sv
// addr_window_map: NUM_WIN programmable windows, 2-stage lookup.
// Ports: CLK, RST_N, bus (slave). Option: MAP_HITCOUNT_EN.
module addr_window_map
  import map_win_pkg::*;
#(
  parameter int NUM_WIN   = 8,
  parameter int ADDR_W    = MAP_ADDR_W,
  parameter int WIN_IDX_W = 4
) (
  input logic CLK,
  input logic RST_N,
  addr_window_map_if.slave bus
);

  map_entry_t shadow_q [NUM_WIN];
  map_entry_t active_q [NUM_WIN];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // commit takes the pre-edge shadow, so a
      // same-cycle write misses this commit
      if (bus.cfg_commit) begin
        for (int i = 0; i < NUM_WIN; i++)
          active_q[i] <= shadow_q[i];
      end
      for (int i = 0; i < NUM_WIN; i++) begin
        if (bus.cfg_we &&
            bus.cfg_win == WIN_IDX_W'(i)) begin
          unique case (1'b1)
            (bus.cfg_field == FIELD_BASE):
              shadow_q[i].base <= bus.cfg_wdata;
            (bus.cfg_field == FIELD_MASK):
              shadow_q[i].mask <= bus.cfg_wdata;
            (bus.cfg_field == FIELD_TARGET):
              shadow_q[i].target <= bus.cfg_wdata;
            (bus.cfg_field == FIELD_FLAGS):
              shadow_q[i].flags <=
                flags_of(bus.cfg_wdata);
          endcase
        end
      end
    end
  end

  logic [NUM_WIN-1:0] win_match;
  logic [ADDR_W-1:0]  win_xlat [NUM_WIN];
  logic [NUM_WIN-1:0] win_wren;

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    map_win_match u_match (
      .entry (active_q[g]),
      .addr  (bus.req_addr),
      .match (win_match[g]),
      .xlat  (win_xlat[g])
    );
    assign win_wren[g] = active_q[g].flags[FLAG_WR];
  end

  // stage 1: snapshot of the active table's verdict
  logic               s1_valid;
  logic               s1_write;
  logic [NUM_WIN-1:0] s1_match;
  logic [NUM_WIN-1:0] s1_wren;
  logic [ADDR_W-1:0]  s1_xlat [NUM_WIN];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_write <= 1'b0;
      s1_match <= '0;
      s1_wren  <= '0;
      for (int i = 0; i < NUM_WIN; i++)
        s1_xlat[i] <= '0;
    end else begin
      s1_valid <= bus.req_valid;
      s1_write <= bus.req_write;
      s1_match <= win_match;
      s1_wren  <= win_wren;
      for (int i = 0; i < NUM_WIN; i++)
        s1_xlat[i] <= win_xlat[i];
    end
  end

  // stage 2: lowest index wins
  logic                 sel_hit;
  logic [WIN_IDX_W-1:0] sel_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_wren;

  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_addr = '0;
    sel_wren = 1'b0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = WIN_IDX_W'(i);
        sel_addr = s1_xlat[i];
        sel_wren = s1_wren[i];
      end
    end
  end

  logic                 resp_valid_q;
  logic                 resp_hit_q;
  logic [WIN_IDX_W-1:0] resp_win_q;
  logic [ADDR_W-1:0]    resp_addr_q;
  logic                 resp_flt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_win_q   <= '0;
      resp_addr_q  <= '0;
      resp_flt_q   <= 1'b0;
    end else begin
      resp_valid_q <= s1_valid;
      // outputs hold while no response
      if (s1_valid) begin
        resp_hit_q  <= sel_hit;
        resp_win_q  <= sel_idx;
        resp_addr_q <= sel_addr;
        resp_flt_q  <= sel_hit & s1_write &
                       ~sel_wren;
      end
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_win      = resp_win_q;
  assign bus.resp_addr     = resp_addr_q;
  assign bus.resp_wr_fault = resp_flt_q;

`ifdef MAP_HITCOUNT_EN
  logic [15:0] hit_cnt_q [NUM_WIN];
  logic [15:0] rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++)
        hit_cnt_q[i] <= '0;
    end else if (bus.cfg_commit) begin
      for (int i = 0; i < NUM_WIN; i++)
        hit_cnt_q[i] <= '0;
    end else if (resp_valid_q && resp_hit_q) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (resp_win_q == WIN_IDX_W'(i) &&
            hit_cnt_q[i] != 16'hFFFF)
          hit_cnt_q[i] <= hit_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (bus.cfg_win == WIN_IDX_W'(i))
        rdata = hit_cnt_q[i];
    end
  end

  assign bus.cfg_rdata = rdata;
`else
  assign bus.cfg_rdata = 16'h0000;
`endif

endmodule

// File: tb/tb_addr_window_map.sv
// Self-checking bench for addr_window_map: directed plan +
// random traffic against a table-level reference model.
module tb_addr_window_map;

  localparam int NW = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  addr_window_map_if #(.ADDR_W(24), .WIN_IDX_W(4)) bif ();

  addr_window_map #(
    .NUM_WIN(NW), .ADDR_W(24), .WIN_IDX_W(4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bif)
  );

  typedef struct {
    logic [23:0] base;
    logic [23:0] mask;
    logic [23:0] tgt;
    logic [23:0] flg;
  } win_t;

  typedef struct {
    bit          v;
    bit          hit;
    logic [3:0]  win;
    logic [23:0] addr;
    bit          flt;
  } resp_t;

  win_t        sh  [16];
  win_t        act [16];
  logic [15:0] cnt [16];
  resp_t       p1, o;
  logic [3:0]  cur_win;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic resp_t lookup(logic [23:0] a, bit w);
    resp_t r;
    r.v = 1'b0; r.hit = 1'b0; r.win = '0;
    r.addr = '0; r.flt = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (act[i].flg[0] &&
          (a & act[i].mask) == (act[i].base & act[i].mask)) begin
        r.hit  = 1'b1;
        r.win  = 4'(i);
        r.addr = act[i].tgt + (a & ~act[i].mask);
        r.flt  = w & ~act[i].flg[1];
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      sh[i]  = '{24'h0, 24'h0, 24'h0, 24'h0};
      act[i] = '{24'h0, 24'h0, 24'h0, 24'h0};
      cnt[i] = 16'h0;
    end
    p1 = '{1'b0, 1'b0, 4'h0, 24'h0, 1'b0};
    o  = '{1'b0, 1'b0, 4'h0, 24'h0, 1'b0};
  endtask

  task automatic check_outputs();
    logic [15:0] exp_rd;
    exp_rd = 16'h0;
`ifdef MAP_HITCOUNT_EN
    if (cur_win < 4'(NW)) exp_rd = cnt[cur_win];
`endif
    chk("resp_valid", 32'(bif.resp_valid), 32'(o.v));
    chk("resp_hit", 32'(bif.resp_hit), 32'(o.hit));
    chk("resp_win", 32'(bif.resp_win), 32'(o.win));
    chk("resp_addr", 32'(bif.resp_addr), 32'(o.addr));
    chk("resp_wr_fault", 32'(bif.resp_wr_fault),
        32'(o.flt));
    chk("cfg_rdata", 32'(bif.cfg_rdata), 32'(exp_rd));
  endtask

  task automatic tick(bit v, logic [23:0] a, bit w,
                      bit we, logic [3:0] win,
                      logic [1:0] fld, logic [23:0] d,
                      bit cm);
    resp_t nr;
    bif.req_valid  = v;
    bif.req_addr   = a;
    bif.req_write  = w;
    bif.cfg_we     = we;
    bif.cfg_win    = win;
    bif.cfg_field  = fld;
    bif.cfg_wdata  = d;
    bif.cfg_commit = cm;
    cur_win = win;
    nr = lookup(a, w);
    nr.v = v;
    @(posedge CLK);
    if (cm) begin
      for (int i = 0; i < 16; i++) cnt[i] = 16'h0;
    end else if (o.v && o.hit && cnt[o.win] != 16'hFFFF) begin
      cnt[o.win] = cnt[o.win] + 16'd1;
    end
    if (cm) begin
      for (int i = 0; i < 16; i++) act[i] = sh[i];
    end
    if (we && win < 4'(NW)) begin
      case (fld)
        2'd0: sh[win].base = d;
        2'd1: sh[win].mask = d;
        2'd2: sh[win].tgt  = d;
        default: sh[win].flg = d;
      endcase
    end
    o.v = p1.v;
    if (p1.v) begin
      o.hit = p1.hit; o.win = p1.win;
      o.addr = p1.addr; o.flt = p1.flt;
    end
    p1 = nr;
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(logic [3:0] win = 4'h0);
    tick(0, 24'h0, 0, 0, win, 2'd0, 24'h0, 0);
  endtask

  task automatic wr(logic [3:0] win, logic [1:0] f,
                    logic [23:0] d);
    tick(0, 24'h0, 0, 1, win, f, d, 0);
  endtask

  task automatic commit();
    tick(0, 24'h0, 0, 0, 4'h0, 2'd0, 24'h0, 1);
  endtask

  task automatic req(logic [23:0] a, bit w);
    tick(1, a, w, 0, 4'h0, 2'd0, 24'h0, 0);
  endtask

  task automatic expect_out(string tag, bit hit,
                            logic [3:0] win,
                            logic [23:0] addr, bit flt);
    chk({tag, "_valid"}, 32'(bif.resp_valid), 32'd1);
    chk({tag, "_hit"}, 32'(bif.resp_hit), 32'(hit));
    chk({tag, "_win"}, 32'(bif.resp_win), 32'(win));
    chk({tag, "_addr"}, 32'(bif.resp_addr), 32'(addr));
    chk({tag, "_flt"}, 32'(bif.resp_wr_fault), 32'(flt));
  endtask

  task automatic prog(logic [3:0] w, logic [23:0] b,
                      logic [23:0] m, logic [23:0] t,
                      logic [23:0] f);
    wr(w, 2'd0, b);
    wr(w, 2'd1, m);
    wr(w, 2'd2, t);
    wr(w, 2'd3, f);
  endtask

  function automatic logic [23:0] rand_mask();
    case ($urandom_range(0, 6))
      0: return 24'hF00000;
      1: return 24'hFF0000;
      2: return 24'hFFF000;
      3: return 24'hE00000;
      4: return 24'h000000;
      5: return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    bif.req_valid = 0; bif.req_addr = '0;
    bif.req_write = 0; bif.cfg_we = 0;
    bif.cfg_win = '0; bif.cfg_field = '0;
    bif.cfg_wdata = '0; bif.cfg_commit = 0;
    cur_win = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_outputs();
    RST_N = 1'b1;

    req(24'h008000, 0); idle();
    expect_out("nomatch", 0, 4'd0, 24'h0, 0);

    prog(4'd0, 24'h400000, 24'hF00000, 24'hC00000, 24'h1);
    commit();
    req(24'h412345, 0); idle();
    expect_out("win0", 1, 4'd0, 24'hC12345, 0);

    prog(4'd1, 24'h0, 24'h0, 24'h100000, 24'h1);
    prog(4'd3, 24'h0, 24'h0, 24'h100000, 24'h1);
    commit();
    req(24'h012345, 0); idle();
    expect_out("ovl1", 1, 4'd1, 24'h112345, 0);
    wr(4'd1, 2'd3, 24'h0);
    commit();
    req(24'h012345, 0); idle();
    expect_out("ovl3", 1, 4'd3, 24'h112345, 0);

    prog(4'd2, 24'h700000, 24'hF00000, 24'h200000, 24'h1);
    commit();
    req(24'h701234, 1); idle();
    expect_out("rofault", 1, 4'd2, 24'h201234, 1);
    req(24'h701234, 0); idle();
    expect_out("roread", 1, 4'd2, 24'h201234, 0);

    wr(4'd9, 2'd3, 24'h3);
    wr(4'd0, 2'd2, 24'hD00000);
    tick(1, 24'h412345, 0, 0, 4'h0, 2'd0, 24'h0, 1);
    req(24'h412345, 0);
    expect_out("oldtbl", 1, 4'd0, 24'hC12345, 0);
    idle();
    expect_out("newtbl", 1, 4'd0, 24'hD12345, 0);

    for (int n = 0; n < 1500; n++) begin
      bit          v, w, we, cm;
      logic [3:0]  win;
      logic [1:0]  fld;
      logic [23:0] d;
      v   = ($urandom_range(0, 9) < 6);
      w   = 1'($urandom);
      we  = ($urandom_range(0, 4) == 0);
      cm  = ($urandom_range(0, 19) == 0);
      win = 4'($urandom_range(0, 15));
      fld = 2'($urandom);
      d   = (fld == 2'd1) ? rand_mask() : 24'($urandom);
      tick(v, 24'($urandom), w, we, win, fld, d, cm);
    end

`ifdef MAP_HITCOUNT_EN
    prog(4'd0, 24'h400000, 24'hF00000, 24'hC00000, 24'h1);
    commit();
    for (int n = 0; n < 70000; n++) req(24'h412345, 0);
    idle(4'd0); idle(4'd0);
    chk("cnt_sat", 32'(bif.cfg_rdata), 32'h0000FFFF);
    commit();
    chk("cnt_clr", 32'(bif.cfg_rdata), 32'h0);
`endif

    req(24'h412345, 0);
    RST_N = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(negedge CLK);
    RST_N = 1'b1;
    idle(); idle();
    chk("rst_flush", 32'(bif.resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_window_map.md
Name: addr_window_map

Overview:
- Parametrised successor to the fixed-mapper address decoder.
- Replaces hard-coded HiROM/LoROM/BS-X decode with NUM_WIN MCU-programmable windows: match base/mask, target offset, enable/writable flags.
- Translates SNES bus addresses to SRAM addresses through a 2-stage pipeline.
- Sits between the SNES bus sampler and the SRAM arbiter; the MCU programs a shadow table and commits it atomically.

Parameters:
- NUM_WIN, 8, number of mapping windows (1..16); lower index has higher priority.
- ADDR_W, 24, width of SNES and SRAM addresses.
- WIN_IDX_W, 4, width of window index fields; must satisfy 2**WIN_IDX_W >= NUM_WIN.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- cfg_we  in  1  shadow-table write strobe.
- cfg_win  in  WIN_IDX_W  target window of write/read.
- cfg_field  in  2  0=base, 1=mask, 2=target, 3=flags.
- cfg_wdata  in  ADDR_W  write data; flags use bit0=enable, bit1=writable.
- cfg_commit  in  1  copy shadow table to active table.
- cfg_rdata  out  16  hit counter of cfg_win (MAP_HITCOUNT_EN only, else 0).
- req_valid  in  1  lookup request.
- req_addr  in  ADDR_W  SNES address.
- req_write  in  1  request is a write.
- resp_valid  out  1  result valid.
- resp_hit  out  1  some enabled window matched.
- resp_win  out  WIN_IDX_W  matching window index.
- resp_addr  out  ADDR_W  translated address.
- resp_wr_fault  out  1  write hit a non-writable window.

Behaviour:
- Reset: every shadow and active field is 0, so all windows are disabled. All resp_* outputs are 0, pipeline is empty, counters are 0.
- Config:
  - cfg_we writes cfg_wdata into the shadow field on the clock edge. cfg_win >= NUM_WIN is ignored.
  - The flags field stores only bits[1:0].
- Commit:
  - cfg_commit copies the whole shadow table into the active table on the edge.
  - A cfg_we in the same cycle as cfg_commit updates the shadow but is NOT part of that commit.
- Match condition for window i: active enable set and (req_addr & mask_i) == (base_i & mask_i).
- Translation: resp_addr = target_i + (req_addr & ~mask_i), modulo 2**ADDR_W; carry is discarded.
- Priority: lowest matching index wins.
- No match: resp_hit=0, resp_win=0, resp_addr=0, resp_wr_fault=0.
- Pipeline stages:
  - Stage 1 registers the per-window match vector, the offsets and req_write.
  - Stage 2 does the priority select and registers the outputs.
  - Latency is exactly 2 cycles; throughput is 1 per cycle; there is no backpressure.
- Table consistency: a request samples the active table in its stage-1 cycle. A commit on that same edge does not affect it; the request uses the old table. The request in the following cycle sees the new table.
- resp_valid mirrors req_valid delayed by 2. When resp_valid=0, the other resp_* outputs hold their previous values.
- resp_wr_fault = hit & req_write & ~writable of the winning window. resp_hit stays 1 in that case; gating the write is the arbiter's job.
- Reset mid-pipeline clears all in-flight requests, so no response is produced.
- mask=0 with enable set matches everything (catch-all window).

Optional Feature:
- MAP_HITCOUNT_EN defined:
  - Each window has a 16-bit counter that increments on every resp_valid & resp_hit for that window.
  - Counters saturate at 0xFFFF.
  - cfg_commit clears all counters; this clear wins over an increment in the same cycle.
  - cfg_rdata = counter[cfg_win], combinational; 0 for out-of-range cfg_win.
- Undefined: no counters exist and cfg_rdata is tied to 0.

Decomposition:
- Package map_win_pkg:
  - Field codes FIELD_BASE=0, FIELD_MASK=1, FIELD_TARGET=2, FIELD_FLAGS=3.
  - Flag bit indices FLAG_EN=0, FLAG_WR=1.
  - A window-entry struct typedef {base, mask, target, flags}.
- Sub-module map_win_match: one per window, generated NUM_WIN times. Takes an entry and an address; produces match and translated address, purely combinational.
- Top level holds the shadow/active tables, the pipeline, the priority encoder and the counters.

Test Plan:
- Reset, then request 0x008000 -> resp_valid at cycle+2, resp_hit=0, resp_addr=0.
- Window 0: base 0x400000, mask 0xF00000, target 0xC00000, flags 1; commit. Request 0x412345 -> hit, win 0, addr 0xC12345.
- Overlapping windows:
  - Window 1: base 0, mask 0, target 0x100000, flags 1; window 3 programmed and committed the same. Request 0x012345 -> win 1, addr 0x112345.
  - Disable window 1 and commit; repeat -> win 3.
- Window 2 with flags 1 (read-only) covering 0x700000. Write request 0x701234 -> resp_hit=1, resp_wr_fault=1. Read request -> resp_wr_fault=0.
- Issue a request in the same cycle as a commit that changes target 0xC00000 -> 0xD00000 -> that response uses 0xC.....; the next cycle's request uses 0xD......
- MAP_HITCOUNT_EN: 70000 hits on window 0 -> cfg_rdata=0xFFFF. Commit -> 0.
